req_priority_scheduler: RTL and testbench
=========================================

Name: req_priority_scheduler

Overview:
- Sequential front stage that collects pulsed requests on 4 channels into sticky pending bits.
- Priority-encodes the pending bits (bit 3 highest, bit 0 lowest) and offers one channel index downstream over a valid/ready handshake.
- Enforces a cooldown after each accepted grant.
- Tracks per-channel request overflow and a running service count.

Parameters:
COOL_CYCLES, 2, idle cycles inserted after each accepted grant; range 0..15.
CNT_W, 8, width of serviced_cnt.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
req  input  4  request pulses, one per channel, sampled every rising edge
grant_ready  input  1  downstream accepts the offered index when high with grant_valid
clr_overflow  input  1  synchronous clear of all overflow bits
grant_valid  output  1  an offered index is present on grant_idx
grant_idx  output  2  offered channel index (3 = highest priority)
pending  output  4  registered sticky pending bits
overflow  output  4  sticky per-channel overflow flags
serviced_cnt  output  CNT_W  count of accepted grants

Behaviour:
- Reset (reset=1 at a rising edge):
  - pending=0, overflow=0, serviced_cnt=0, grant_valid=0, grant_idx=0.
  - FSM=IDLE, cooldown counter=0.
  - Reset overrides all other inputs, including mid-OFFER or mid-COOL; an offered grant is dropped without counting.
- Pending update, per bit i, every edge:
  - pending[i] <= (pending[i] & ~clr_i) | req[i].
  - clr_i is 1 only on the OFFER-state edge where grant_valid & grant_ready and grant_idx==i.
  - Set wins: a req on the same channel in the acceptance cycle re-pends that bit and is not an overflow.
- Overflow, per bit i:
  - Set when req[i] & pending[i] & ~clr_i.
  - Cleared by clr_overflow.
  - A set on the same edge as clr_overflow wins (bit ends 1).
- FSM states: IDLE, OFFER, COOL.
- IDLE:
  - If pending != 0 at the edge: latch grant_idx = highest set pending bit, set grant_valid=1, go to OFFER.
  - Uses registered pending, so a req sampled at edge E0 produces grant_valid high after edge E1 (2-edge latency).
  - Otherwise stay in IDLE.
- OFFER:
  - grant_valid=1; grant_idx frozen with no preemption, even if a higher-priority request arrives.
  - On an edge with grant_ready=1: clear the pending bit, serviced_cnt += 1 (wraps modulo 2^CNT_W), grant_valid=0.
  - Then go to COOL with counter loaded to COOL_CYCLES; if COOL_CYCLES==0, go directly to IDLE.
  - grant_ready=0: hold all grant outputs indefinitely.
- COOL:
  - grant_valid=0; decrement the counter each edge.
  - When counter==1 at the edge, go to IDLE.
  - Requests continue to accumulate into pending during COOL.
  - Next OFFER appears after the IDLE evaluation edge: COOL_CYCLES + 1 edges after acceptance.
- Idle outputs: grant_idx holds its last offered value while grant_valid=0.
- grant_ready while grant_valid=0 has no effect.
- Multiple simultaneous req bits all set pending; they are served in priority order, one per grant cycle.
- All outputs are driven directly from registers; there is no combinational input-to-output path.

Test Plan:
1. Reset, then req=4'b1000 for one cycle, grant_ready=1 → grant_valid high 2 edges after req, grant_idx=3, accepted on the next edge; pending=0, serviced_cnt=1.
2. req=4'b0110 for one cycle, grant_ready=1, COOL_CYCLES=2 → grants idx 2 then idx 1, with grant_valid pulses separated by 3 low cycles; serviced_cnt=2; overflow=0.
3. grant_ready=0, req=4'b0001, then req=4'b1000 while in OFFER → grant_idx stays 0 until grant_ready=1; the next grant is idx 3.
4. req[2] pulsed twice before service → overflow=4'b0100. Then clr_overflow=1 together with another req[2] while pending → overflow stays 4'b0100. clr_overflow alone → overflow=0.
5. req[1] pulsed in the same cycle its grant is accepted → no overflow, pending[1]=1 after the edge, idx 1 offered again after cooldown.
6. reset asserted during OFFER (idx 2 offered) → next cycle grant_valid=0, pending=0, serviced_cnt=0, FSM=IDLE. Also run 256 accepts with CNT_W=8 → serviced_cnt wraps to 0.

Source files
------------

// File: rtl/req_priority_scheduler.sv
// Four-channel sticky request collector with fixed-priority valid/ready grant offer,
// post-grant cooldown, per-channel overflow flags and a wrapping service counter.
module req_priority_scheduler #(
    parameter int unsigned COOL_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic             grant_ready,
    input  logic             clr_overflow,
    output logic             grant_valid,
    output logic [1:0]       grant_idx,
    output logic [3:0]       pending,
    output logic [3:0]       overflow,
    output logic [CNT_W-1:0] serviced_cnt
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StOffer = 2'd1,
        StCool  = 2'd2
    } state_e;

    localparam logic [3:0] LP_COOL_LOAD = 4'(COOL_CYCLES);

    state_e           r_state;
    logic [3:0]       r_cool;
    logic [3:0]       r_pending;
    logic [3:0]       r_overflow;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic [1:0]       r_idx;

    state_e           w_state_next;
    logic [3:0]       w_cool_next;
    logic [3:0]       w_pending_next;
    logic [3:0]       w_overflow_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_valid_next;
    logic [1:0]       w_idx_next;
    logic             w_accept;
    logic [3:0]       w_clr;
    logic [1:0]       w_top_idx;

    // Highest set pending bit wins; later iterations override lower channels.
    always_comb begin
        w_top_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_pending[i]) begin
                w_top_idx = 2'(i);
            end
        end
    end

    assign w_accept = (r_state == StOffer) && grant_ready;
    assign w_clr    = w_accept ? (4'b0001 << r_idx) : 4'b0000;

    // A request arriving on the acceptance edge re-pends its bit and is not an overflow.
    always_comb begin
        w_pending_next  = (r_pending & ~w_clr) | req;
        w_overflow_next = (clr_overflow ? 4'b0000 : r_overflow) | (req & r_pending & ~w_clr);
    end

    always_comb begin
        w_state_next = r_state;
        w_cool_next  = r_cool;
        w_cnt_next   = r_cnt;
        w_valid_next = r_valid;
        w_idx_next   = r_idx;
        unique case (r_state)
            StIdle: begin
                if (r_pending != 4'b0000) begin
                    w_idx_next   = w_top_idx;
                    w_valid_next = 1'b1;
                    w_state_next = StOffer;
                end
            end
            StOffer: begin
                if (grant_ready) begin
                    w_valid_next = 1'b0;
                    w_cnt_next   = r_cnt + CNT_W'(1);
                    w_cool_next  = LP_COOL_LOAD;
                    w_state_next = (COOL_CYCLES == 0) ? StIdle : StCool;
                end
            end
            StCool: begin
                w_cool_next = r_cool - 4'd1;
                if (r_cool <= 4'd1) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cool     <= 4'd0;
            r_pending  <= 4'b0000;
            r_overflow <= 4'b0000;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_idx      <= 2'd0;
        end else begin
            r_state    <= w_state_next;
            r_cool     <= w_cool_next;
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
            r_cnt      <= w_cnt_next;
            r_valid    <= w_valid_next;
            r_idx      <= w_idx_next;
        end
    end

    assign grant_valid  = r_valid;
    assign grant_idx    = r_idx;
    assign pending      = r_pending;
    assign overflow     = r_overflow;
    assign serviced_cnt = r_cnt;

endmodule

// File: tb/tb_req_priority_scheduler.sv
// Directed bench for req_priority_scheduler: an edge-count based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_req_priority_scheduler;

    localparam int unsigned COOL  = 2;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       req = 4'b0000;
    logic             grant_ready = 1'b0;
    logic             clr_overflow = 1'b0;
    logic             grant_valid;
    logic [1:0]       grant_idx;
    logic [3:0]       pending;
    logic [3:0]       overflow;
    logic [CNT_W-1:0] serviced_cnt;

    int n_checks = 0;
    int n_errors = 0;

    req_priority_scheduler #(
        .COOL_CYCLES(COOL),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant_ready (grant_ready),
        .clr_overflow(clr_overflow),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .pending     (pending),
        .overflow    (overflow),
        .serviced_cnt(serviced_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant may be latched only at edges at or after m_early, which is
    // COOL+1 edges past the previous acceptance.
    logic [3:0]       m_pend = '0, m_ov = '0, m_pend_nx, m_ov_nx, m_clr;
    logic [CNT_W-1:0] m_cnt = '0, m_cnt_nx;
    logic             m_valid = 1'b0, m_valid_nx;
    logic [1:0]       m_idx = '0, m_idx_nx;
    int               m_early = 0, m_early_nx;
    int               edge_n = 0;
    bit               m_live = 1'b0;

    always_comb begin
        m_clr      = (m_valid && grant_ready) ? (4'b0001 << m_idx) : 4'b0000;
        m_ov_nx    = (clr_overflow ? 4'b0000 : m_ov) | (req & m_pend & ~m_clr);
        m_pend_nx  = (m_pend & ~m_clr) | req;
        m_valid_nx = m_valid;
        m_idx_nx   = m_idx;
        m_cnt_nx   = m_cnt;
        m_early_nx = m_early;
        if (m_valid) begin
            if (grant_ready) begin
                m_valid_nx = 1'b0;
                m_cnt_nx   = m_cnt + 1'b1;
                m_early_nx = edge_n + int'(COOL) + 1;
            end
        end else if (edge_n >= m_early && m_pend != 4'b0000) begin
            m_valid_nx = 1'b1;
            if (m_pend[3])      m_idx_nx = 2'd3;
            else if (m_pend[2]) m_idx_nx = 2'd2;
            else if (m_pend[1]) m_idx_nx = 2'd1;
            else                m_idx_nx = 2'd0;
        end
    end

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (reset) begin
            m_live  <= 1'b1;
            m_pend  <= '0;
            m_ov    <= '0;
            m_cnt   <= '0;
            m_valid <= 1'b0;
            m_idx   <= 2'd0;
            m_early <= edge_n + 1;
        end else begin
            m_pend  <= m_pend_nx;
            m_ov    <= m_ov_nx;
            m_cnt   <= m_cnt_nx;
            m_valid <= m_valid_nx;
            m_idx   <= m_idx_nx;
            m_early <= m_early_nx;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("mdl_valid", 32'(grant_valid), 32'(m_valid));
                chk("mdl_idx", 32'(grant_idx), 32'(m_idx));
                chk("mdl_pending", 32'(pending), 32'(m_pend));
                chk("mdl_overflow", 32'(overflow), 32'(m_ov));
                chk("mdl_cnt", 32'(serviced_cnt), 32'(m_cnt));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = 4'b0000; grant_ready = 1'b0; clr_overflow = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic wait_valid(input string name, output int waited);
        waited = 0;
        while (!grant_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!grant_valid) chk({name, "_timeout"}, 32'(grant_valid), 32'd1);
    endtask

    initial begin
        int w;
        int acc;
        int cyc;
        // 1: single top-priority request, two-edge latency
        do_reset();
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_idx", 32'(grant_idx), 32'd0);
        chk("rst_cnt", 32'(serviced_cnt), 32'd0);
        grant_ready = 1'b1;
        pulse(4'b1000);
        chk("t1_pend", 32'(pending), 32'h8);
        chk("t1_not_yet", 32'(grant_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(grant_valid), 32'd1);
        chk("t1_idx", 32'(grant_idx), 32'd3);
        @(negedge clk);
        chk("t1_done", 32'(grant_valid), 32'd0);
        chk("t1_pend0", 32'(pending), 32'h0);
        chk("t1_cnt", 32'(serviced_cnt), 32'd1);

        // 2: two simultaneous requests, priority order, cooldown gap
        do_reset();
        grant_ready = 1'b1;
        pulse(4'b0110);
        wait_valid("t2a", w);
        chk("t2_idx_a", 32'(grant_idx), 32'd2);
        @(negedge clk);
        w = 0;
        while (!grant_valid && w < 20) begin
            w++;
            @(negedge clk);
        end
        chk("t2_gap", 32'(w), 32'd3);
        chk("t2_idx_b", 32'(grant_idx), 32'd1);
        @(negedge clk);
        chk("t2_cnt", 32'(serviced_cnt), 32'd2);
        chk("t2_ov", 32'(overflow), 32'd0);

        // 3: no preemption while offered
        do_reset();
        pulse(4'b0001);
        wait_valid("t3a", w);
        chk("t3_idx0", 32'(grant_idx), 32'd0);
        pulse(4'b1000);
        repeat (3) @(negedge clk);
        chk("t3_hold_v", 32'(grant_valid), 32'd1);
        chk("t3_hold_idx", 32'(grant_idx), 32'd0);
        chk("t3_pend", 32'(pending), 32'h9);
        grant_ready = 1'b1;
        @(negedge clk);
        wait_valid("t3b", w);
        chk("t3_idx3", 32'(grant_idx), 32'd3);
        @(negedge clk);
        grant_ready = 1'b0;

        // 4: overflow set, set-wins over clear, then clear
        do_reset();
        pulse(4'b0100);
        wait_valid("t4", w);
        pulse(4'b0100);
        chk("t4_ov", 32'(overflow), 32'h4);
        @(negedge clk);
        clr_overflow = 1'b1; req = 4'b0100;
        @(negedge clk);
        clr_overflow = 1'b0; req = 4'b0000;
        chk("t4_ov_setwin", 32'(overflow), 32'h4);
        @(negedge clk);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("t4_ov_clr", 32'(overflow), 32'h0);

        // 5: re-request on the acceptance edge
        do_reset();
        pulse(4'b0010);
        wait_valid("t5a", w);
        chk("t5_idx", 32'(grant_idx), 32'd1);
        grant_ready = 1'b1; req = 4'b0010;
        @(negedge clk);
        grant_ready = 1'b0; req = 4'b0000;
        chk("t5_valid0", 32'(grant_valid), 32'd0);
        chk("t5_pend", 32'(pending), 32'h2);
        chk("t5_ov", 32'(overflow), 32'h0);
        chk("t5_cnt", 32'(serviced_cnt), 32'd1);
        wait_valid("t5b", w);
        chk("t5_gap", 32'(w), 32'd3);
        chk("t5_idx_again", 32'(grant_idx), 32'd1);

        // 6: reset mid-offer, then counter wrap
        do_reset();
        pulse(4'b0100);
        wait_valid("t6", w);
        chk("t6_idx", 32'(grant_idx), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_valid", 32'(grant_valid), 32'd0);
        chk("t6_pend", 32'(pending), 32'h0);
        chk("t6_cnt", 32'(serviced_cnt), 32'd0);
        grant_ready = 1'b1; req = 4'b0001;
        acc = 0; cyc = 0;
        while (acc < 256 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (grant_valid) acc++;
            if (acc == 255 && grant_valid) chk("t6_cnt_ff", 32'(serviced_cnt), 32'hFE);
        end
        chk("t6_accepts", 32'(acc), 32'd256);
        @(negedge clk);
        grant_ready = 1'b0; req = 4'b0000;
        chk("t6_wrap", 32'(serviced_cnt), 32'd0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
